// File: rtl/soc_system_pio_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the PIO interrupt controller.
interface soc_system_pio_irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_pio_irq_ctrl.sv
// Multi-channel PIO input port: per-channel synchroniser, debounce filter, rise/fall edge
// capture into a W1C register, and a masked level interrupt.
module soc_system_pio_irq_ctrl #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      CNT_W       = 16,
  parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  soc_system_pio_irq_ctrl_if.slave   bus,
  input  logic [WIDTH-1:0]           in_port,
  output logic                       irq
);

  localparam logic [2:0] AddrData     = 3'd0;
  localparam logic [2:0] AddrRiseEn   = 3'd1;
  localparam logic [2:0] AddrIrqMask  = 3'd2;
  localparam logic [2:0] AddrCapture  = 3'd3;
  localparam logic [2:0] AddrFallEn   = 3'd4;
  localparam logic [2:0] AddrDebounce = 3'd5;
  localparam logic [2:0] AddrPending  = 3'd6;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [CNT_W-1:0] debounce_q, debounce_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] update;
  logic [WIDTH-1:0] w1c;
  logic             wr_en;
  logic             unused_wdata;

  assign y            = sync_q[SYNC_STAGES-1];
  assign wr_en        = bus.chipselect & ~bus.write_n;
  // Upper writedata bits beyond WIDTH/CNT_W are deliberately ignored.
  assign unused_wdata = ^bus.writedata;

  // Shift each input through the synchroniser chain.
  always_comb begin
    sync_d[0] = in_port;
    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Debounce: filt follows y once y has differed for D+1 clocks; cnt above D reloads to 0.
  always_comb begin
    filt_d = filt_q;
    update = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (y[i] != filt_q[i]) begin
        if (cnt_q[i] == debounce_q) begin
          filt_d[i] = y[i];
          update[i] = 1'b1;
        end else if (cnt_q[i] < debounce_q) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Register writes and edge capture; a new edge wins over a simultaneous W1C.
  always_comb begin
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    mask_d     = mask_q;
    debounce_d = debounce_q;
    w1c        = '0;
    if (wr_en) begin
      case (bus.address)
        AddrRiseEn:   rise_en_d  = bus.writedata[WIDTH-1:0];
        AddrIrqMask:  mask_d     = bus.writedata[WIDTH-1:0];
        AddrCapture:  w1c        = bus.writedata[WIDTH-1:0];
        AddrFallEn:   fall_en_d  = bus.writedata[WIDTH-1:0];
        AddrDebounce: debounce_d = bus.writedata[CNT_W-1:0];
        default:      ;
      endcase
    end
    capture_d = (capture_q & ~w1c)
              | (update & y & rise_en_q)
              | (update & ~y & fall_en_q);
  end

  // Read mux, registered every clock regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      AddrData:     readdata_d[WIDTH-1:0] = filt_q;
      AddrRiseEn:   readdata_d[WIDTH-1:0] = rise_en_q;
      AddrIrqMask:  readdata_d[WIDTH-1:0] = mask_q;
      AddrCapture:  readdata_d[WIDTH-1:0] = capture_q;
      AddrFallEn:   readdata_d[WIDTH-1:0] = fall_en_q;
      AddrDebounce: readdata_d[CNT_W-1:0] = debounce_q;
      AddrPending:  readdata_d[WIDTH-1:0] = capture_q & mask_q;
      default:      ;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      filt_q     <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      mask_q     <= RESET_MASK;
      capture_q  <= '0;
      debounce_q <= '0;
      readdata_q <= '0;
    end else begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      filt_q     <= filt_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      mask_q     <= mask_d;
      capture_q  <= capture_d;
      debounce_q <= debounce_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(capture_q & mask_q);

endmodule
